// File: rtl/ulpi_reg_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ulpi_reg_sequencer_pkg                                         |
// | Purpose  : Shared constants for the ULPI register sequencer: USB3300     |
// |            register addresses, sniffer-mode init values, init table      |
// |            size and the sequencer state encoding.                        |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ulpi_reg_sequencer_pkg;

  // USB3300 register addresses
  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] IFC_CTRL  = 6'h07;
  localparam logic [5:0] OTG_CTRL  = 6'h0A;

  // Sniffer-mode values: FS transceiver, non-driving opmode, SuspendM=1,
  // pulldowns off, default interface control.
  localparam logic [7:0] FUNC_CTRL_SNIFF = 8'h49;
  localparam logic [7:0] OTG_CTRL_SNIFF  = 8'h00;
  localparam logic [7:0] IFC_CTRL_DEF    = 8'h00;

  localparam int N_INIT     = 3;
  localparam int INIT_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_RST_WAIT   = 3'd0,
    ST_INIT_ISSUE = 3'd1,
    ST_INIT_WAIT  = 3'd2,
    ST_IDLE       = 3'd3,
    ST_USR_WAIT   = 3'd4
  } seq_state_e;

  // Packs one init table entry as {addr, data}.
  function automatic logic [13:0] init_entry(input logic [5:0] addr,
                                             input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ulpi_reg_sequencer_init_rom.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ulpi_init_rom                                                  |
// | Purpose  : Combinational boot-init table, idx -> {addr, data}.           |
// |            Order: FUNC_CTRL, OTG_CTRL, IFC_CTRL.                          |
// | Ports    : idx  in  INIT_IDX_W  table index                              |
// |            addr out 6           register address                        |
// |            data out 8           register value                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ulpi_init_rom
  import ulpi_reg_sequencer_pkg::*;
(
  input  logic [INIT_IDX_W-1:0] idx,
  output logic [5:0]            addr,
  output logic [7:0]            data
);

  logic [13:0] entry;

  always_comb begin
    entry = '0;
    case (idx)
      2'd0:    entry = init_entry(FUNC_CTRL, FUNC_CTRL_SNIFF);
      2'd1:    entry = init_entry(OTG_CTRL,  OTG_CTRL_SNIFF);
      2'd2:    entry = init_entry(IFC_CTRL,  IFC_CTRL_DEF);
      default: entry = '0;
    endcase
  end

  assign addr = entry[13:8];
  assign data = entry[7:0];

endmodule
`default_nettype wire

// File: rtl/ulpi_reg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ulpi_reg_sequencer                                             |
// | Purpose  : Shares the ULPI register-write engine between a boot init     |
// |            table and a runtime user write port. Init runs once after     |
// |            reset; user writes are served afterwards.                    |
// | Ports    : clk        in   ULPI 60 MHz clock                              |
// |            rst_n      in   async active-low reset                         |
// |            DIR        in   ULPI DIR, PHY owns bus while high              |
// |            USR_REQ    in   user write request (level, held until ack)     |
// |            USR_ADDR   in   [5:0] user register address                   |
// |            USR_DATA   in   [7:0] user register data                      |
// |            USR_ACK    out  1-cycle completion/timeout pulse              |
// |            USR_BUSY   out  high whenever not IDLE                        |
// |            WRITE_DATA out  1-cycle start pulse to the register writer    |
// |            ADDR       out  [5:0] address to the register writer          |
// |            DATA       out  [7:0] data to the register writer             |
// |            BUSY       in   register writer busy                          |
// |            INIT_DONE  out  sticky, all init entries issued               |
// |            ERROR      out  sticky, any transaction timed out             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ulpi_reg_sequencer
  import ulpi_reg_sequencer_pkg::*;
#(
  parameter int STARTUP_WAIT = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       DIR,
  input  logic       USR_REQ,
  input  logic [5:0] USR_ADDR,
  input  logic [7:0] USR_DATA,
  output logic       USR_ACK,
  output logic       USR_BUSY,
  output logic       WRITE_DATA,
  output logic [5:0] ADDR,
  output logic [7:0] DATA,
  input  logic       BUSY,
  output logic       INIT_DONE,
  output logic       ERROR
);

  // One counter serves both the startup wait and the transaction timeout.
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int STW_W = $clog2(STARTUP_WAIT + 1);
  localparam int CNT_W = (TMO_W > STW_W) ? TMO_W : STW_W;

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [INIT_IDX_W-1:0] idx_q, idx_d;
  logic                  busy_seen_q, busy_seen_d;
  logic                  write_data_q, write_data_d;
  logic [5:0]            addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  usr_ack_q, usr_ack_d;
  logic                  init_done_q, init_done_d;
  logic                  error_q, error_d;

  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic       bus_free;
  logic       busy_fell;
  logic       timed_out;

  ulpi_init_rom u_init_rom (
    .idx  (idx_q),
    .addr (rom_addr),
    .data (rom_data)
  );

  assign bus_free  = !DIR && !BUSY;
  // A fall only counts once the writer has actually accepted the request.
  assign busy_fell = busy_seen_q && !BUSY;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    busy_seen_d  = busy_seen_q;
    write_data_d = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    usr_ack_d    = 1'b0;
    init_done_d  = init_done_q;
    error_d      = error_q;

    case (state_q)
      ST_RST_WAIT: begin
        if (cnt_q == CNT_W'(STARTUP_WAIT - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_INIT_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_INIT_ISSUE: begin
        if (bus_free) begin
          addr_d       = rom_addr;
          data_d       = rom_data;
          write_data_d = 1'b1;
          cnt_d        = '0;
          busy_seen_d  = 1'b0;
          state_d      = ST_INIT_WAIT;
        end
      end

      ST_INIT_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (BUSY) begin
          busy_seen_d = 1'b1;
        end
        if (busy_fell || timed_out) begin
          if (!busy_fell) begin
            error_d = 1'b1;
          end
          if (idx_q == INIT_IDX_W'(N_INIT - 1)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_INIT_ISSUE;
          end
        end
      end

      ST_IDLE: begin
        // The ack cycle is spent in IDLE; the still-held request from the
        // finished transaction must not start a second write.
        if (USR_REQ && bus_free && !usr_ack_q) begin
          addr_d       = USR_ADDR;
          data_d       = USR_DATA;
          write_data_d = 1'b1;
          cnt_d        = '0;
          busy_seen_d  = 1'b0;
          state_d      = ST_USR_WAIT;
        end
      end

      ST_USR_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (BUSY) begin
          busy_seen_d = 1'b1;
        end
        if (busy_fell || timed_out) begin
          if (!busy_fell) begin
            error_d = 1'b1;
          end
          usr_ack_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_RST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST_WAIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      busy_seen_q  <= 1'b0;
      write_data_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      usr_ack_q    <= 1'b0;
      init_done_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      busy_seen_q  <= busy_seen_d;
      write_data_q <= write_data_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      usr_ack_q    <= usr_ack_d;
      init_done_q  <= init_done_d;
      error_q      <= error_d;
    end
  end

  assign WRITE_DATA = write_data_q;
  assign ADDR       = addr_q;
  assign DATA       = data_q;
  assign USR_ACK    = usr_ack_q;
  assign USR_BUSY   = (state_q != ST_IDLE);
  assign INIT_DONE  = init_done_q;
  assign ERROR      = error_q;

endmodule
`default_nettype wire
